control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port INSTRUCTION, input, 32 bits: current IR contents from the datapath.
REQ-004 SHALL have port ZERO, input, 1 bit: ALU zero flag from the datapath.
REQ-005 SHALL have port CTRL, output, 32 bits: datapath control word, with bits as listed in REQ-010.
REQ-006 SHALL have port READ, output, 1 bit: memory read strobe.
REQ-007 SHALL have port WRITE, output, 1 bit: memory write strobe.
REQ-008 SHALL have port ERR, output, 1 bit: illegal-instruction flag.

Function
REQ-009 SHALL sequence the states FETCH->DECODE->EXE->MEM->WB->FETCH, one state per CLK, so that every instruction takes exactly 5 cycles.
REQ-010 SHALL use this CTRL bit map: 0 pc_load; 1-3 pc_sel_1..3; 4 ir_load; 5 r1_sel_1; 6 reg_r; 7 reg_w; 8 sp_load; 9 op1_sel_1; 10-13 op2_sel_1..4; 19:14 alu_oprn; 20-21 ma_sel_1..2; 22 md_sel_1; 23-25 wd_sel_1..3; 26-28 wa_sel_1..3; 31:29 zero.
REQ-011 SHALL drive CTRL, READ and WRITE as registered outputs, updated on the same edge as the state change, so they are valid for the whole state.
REQ-012 FETCH SHALL drive READ=1, WRITE=0, ma_sel_2=1 (address=PC), and all other CTRL bits to 0.
REQ-013 DECODE SHALL hold READ=1 and ma_sel_2=1, and SHALL assert ir_load=1 and reg_r=1.
REQ-014 EXE SHALL select the operands and alu_oprn for the decoded opcode/funct: R-type uses op2_sel_4=1 (r2); shifts use shamt; addi/muli/slti use imm_sx; andi/ori use imm_zx; lw/sw use add with imm_sx; beq/bne use sub on r1,r2; push/pop use op1_sel_1=1 (SP) with the constant 1.
REQ-015 MEM SHALL drive READ=1 with the ALU address for lw, WRITE=1 for sw, WRITE=1 with ma_sel_1=1 and md_sel_1=1 for push (mem[SP]<=R[rs]), and READ=1 with the SP+1 address for pop; READ=WRITE=0 for all other instructions.
REQ-016 WB SHALL assert pc_load=1 for every instruction; PC source: PC+1 by default, r1 for jr, PC+1+imm_sx for beq with ZERO=1 or bne with ZERO=0, and addr26 for jmp/jal.
REQ-017 WB SHALL assert reg_w=1 with the correct wa_sel/wd_sel for R-type (rd), I-type arithmetic/lui/lw/pop (rt), and jal (R31 <= PC+1); sp_load=1 SHALL occur in EXE for pop and in WB for push.
REQ-018 READ and WRITE SHALL never be 1 simultaneously.
REQ-019 Opcode and funct decoding SHALL be combinational from INSTRUCTION and SHALL be sampled only in EXE, MEM and WB.

Reset
REQ-020 RST=0 SHALL immediately force state=FETCH-pending and CTRL=0, READ=0, WRITE=0, ERR=0, regardless of the current state, including mid-instruction.
REQ-021 On the first rising edge of CLK after RST rises, the block SHALL enter FETCH.

Configuration
REQ-022 With macro CTRL_ILLEGAL_TRAP_EN defined, an undefined opcode or funct seen in EXE SHALL move the block to state HALT with ERR=1, CTRL=0, READ=WRITE=0, held until reset.
REQ-023 Without CTRL_ILLEGAL_TRAP_EN, an undefined opcode or funct SHALL execute as a NOP (PC+1 only), and ERR SHALL be tied to 0.

Structure
REQ-024 State encodings, opcode/funct constants, ALU opcodes (add=1, sub=2, mul=3, srl=4, sll=5, and=6, or=7, nor=8, slt=9) and CTRL bit indices SHALL reside in prj_definition.v.
REQ-025 The state register and next-state logic SHALL be a sub-module PROC_SM; control-word generation SHALL remain in control_unit.

Verification
REQ-026 Reset release followed by 5 clocks with INSTRUCTION=add r3,r1,r2 -> states FETCH..WB, alu_oprn=1 in EXE, reg_w=1 and pc_load=1 in WB only.
REQ-027 beq, once with ZERO=1 and once with ZERO=0 in EXE -> WB pc_sel selects PC+1+imm and PC+1 respectively.
REQ-028 sw then lw -> WRITE=1 for exactly the single MEM cycle, READ=1 in MEM, reg_w=1 with wd_sel selecting memory data in WB.
REQ-029 push then pop -> MEM WRITE with ma_sel_1=1 and md_sel_1=1, sp_load in WB; pop sp_load in EXE, READ in MEM, reg_w in WB.
REQ-030 RST pulled low during MEM of sw -> WRITE drops to 0 asynchronously; after release the block restarts at FETCH.
REQ-031 Opcode 0x3F -> ERR=1 and the block sticks in HALT when CTRL_ILLEGAL_TRAP_EN is defined; otherwise 5 cycles with only pc_load in WB.

Source files
------------

// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the multi-cycle control unit.
//   - state_e : sequencer states
//   - opcode / funct constants of the supported instruction set
//   - ALU operation codes carried in CTRL[19:14]
//   - CTRL bit indices and the operand-2 select encoding
//   - dec_t   : decoded instruction summary used to build control words
package control_unit_pkg;

    typedef enum logic [2:0] {
        StReset  = 3'd0,  // reset asserted / first FETCH pending
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExe    = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    // Opcodes
    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJmp   = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0a;
    localparam logic [5:0] OpAndi  = 6'h0c;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpPush  = 6'h1b;
    localparam logic [5:0] OpPop   = 6'h1c;
    localparam logic [5:0] OpMuli  = 6'h1d;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FnSll = 6'h01;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnNor = 6'h27;
    localparam logic [5:0] FnSlt = 6'h2a;
    localparam logic [5:0] FnMul = 6'h2c;

    // ALU operations
    localparam logic [5:0] AluAdd = 6'd1;
    localparam logic [5:0] AluSub = 6'd2;
    localparam logic [5:0] AluMul = 6'd3;
    localparam logic [5:0] AluSrl = 6'd4;
    localparam logic [5:0] AluSll = 6'd5;
    localparam logic [5:0] AluAnd = 6'd6;
    localparam logic [5:0] AluOr  = 6'd7;
    localparam logic [5:0] AluNor = 6'd8;
    localparam logic [5:0] AluSlt = 6'd9;

    // CTRL bit indices. Mux selects are one-hot; all-zero picks the default source:
    //   pc     : PC+1       | sel_1 r1, sel_2 PC+1+imm_sx, sel_3 addr26
    //   op1    : r1         | sel_1 SP
    //   op2    : imm_sx     | sel_1 const 1, sel_2 shamt, sel_3 imm_zx, sel_4 r2
    //   maddr  : ALU result | sel_1 SP, sel_2 PC
    //   mdata  : r2         | sel_1 r1
    //   wdata  : ALU result | sel_1 mem data, sel_2 {imm,16'h0}, sel_3 PC+1
    //   waddr  : rd         | sel_1 rt, sel_2 R0 (unused), sel_3 R31
    //   r1 addr: rs         | sel_1 R0 (unused)
    localparam int unsigned CtlPcLoad  = 0;
    localparam int unsigned CtlPcSel1  = 1;
    localparam int unsigned CtlPcSel2  = 2;
    localparam int unsigned CtlPcSel3  = 3;
    localparam int unsigned CtlIrLoad  = 4;
    localparam int unsigned CtlR1Sel1  = 5;
    localparam int unsigned CtlRegR    = 6;
    localparam int unsigned CtlRegW    = 7;
    localparam int unsigned CtlSpLoad  = 8;
    localparam int unsigned CtlOp1Sel1 = 9;
    localparam int unsigned CtlOp2Sel1 = 10;
    localparam int unsigned CtlOp2Sel4 = 13;
    localparam int unsigned CtlAluLsb  = 14;
    localparam int unsigned CtlAluMsb  = 19;
    localparam int unsigned CtlMaSel1  = 20;
    localparam int unsigned CtlMaSel2  = 21;
    localparam int unsigned CtlMdSel1  = 22;
    localparam int unsigned CtlWdSel1  = 23;
    localparam int unsigned CtlWdSel2  = 24;
    localparam int unsigned CtlWdSel3  = 25;
    localparam int unsigned CtlWaSel1  = 26;
    localparam int unsigned CtlWaSel2  = 27;
    localparam int unsigned CtlWaSel3  = 28;

    // Operand-2 select field, bit 0 = op2_sel_1
    localparam logic [3:0] Op2ImmSx = 4'b0000;
    localparam logic [3:0] Op2Const = 4'b0001;
    localparam logic [3:0] Op2Shamt = 4'b0010;
    localparam logic [3:0] Op2ImmZx = 4'b0100;
    localparam logic [3:0] Op2R2    = 4'b1000;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       op1_sp;
        logic [3:0] op2_sel;
        logic       wr_rd;    // write-back to rd
        logic       wr_rt;    // write-back to rt
        logic       wd_mem;   // write-back data from memory
        logic       wd_lui;
        logic       is_lw;
        logic       is_sw;
        logic       is_push;
        logic       is_pop;
        logic       is_beq;
        logic       is_bne;
        logic       is_jr;
        logic       is_jump;  // jmp or jal
        logic       is_jal;
    } dec_t;

endpackage

// File: rtl/control_unit_proc_sm.sv
// control_unit_proc_sm: instruction sequencer for the control unit.
//   FETCH -> DECODE -> EXE -> MEM -> WB -> FETCH, one state per clock.
//   A trap request seen in EXE moves to HALT, which is left only by reset.
// Ports:
//   clk_i        - clock
//   rst_ni       - asynchronous active-low reset (state -> StReset)
//   trap_i       - illegal instruction in EXE
//   state_o      - current state
//   state_next_o - state that will be entered on the next clock edge
module control_unit_proc_sm
    import control_unit_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   trap_i,
    output state_e state_o,
    output state_e state_next_o
);

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReset:  state_d = StFetch;
            StFetch:  state_d = StDecode;
            StDecode: state_d = StExe;
            StExe:    state_d = trap_i ? StHalt : StMem;
            StMem:    state_d = StWb;
            StWb:     state_d = StFetch;
            StHalt:   state_d = StHalt;
            default:  state_d = StReset;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o      = state_q;
    assign state_next_o = state_d;

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle control unit producing the datapath control word.
// Every output is registered: the word for a state is built from the state
// about to be entered, so it is valid for that whole state.
// Ports:
//   CLK         - clock, rising edge
//   RST         - asynchronous active-low reset
//   INSTRUCTION - IR contents from the datapath
//   ZERO        - ALU zero flag, captured at the end of EXE for branches
//   CTRL        - 32-bit control word (bit map in control_unit_pkg)
//   READ/WRITE  - memory strobes, never both high
//   ERR         - illegal-instruction flag
// Build option CTRL_ILLEGAL_TRAP_EN: undefined opcode/funct in EXE halts with
// ERR=1 until reset. Without it such instructions run as NOPs and ERR is 0.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [31:0] CTRL,
    output logic        READ,
    output logic        WRITE,
    output logic        ERR
);

    state_e      state_q, state_next;
    dec_t        dec;
    logic        legal, trap;
    logic [5:0]  opcode, funct;
    logic [31:0] ctrl_d, ctrl_q;
    logic        read_d, read_q, write_d, write_q, zero_q;
    logic        unused_instr;

    assign opcode       = INSTRUCTION[31:26];
    assign funct        = INSTRUCTION[5:0];
    // Register and immediate fields go straight to the datapath.
    assign unused_instr = ^INSTRUCTION[25:6];

    // Instruction decode; anything undefined collapses to an all-zero summary (NOP).
    always_comb begin
        dec   = '0;
        legal = 1'b1;
        unique case (opcode)
            OpRtype: begin
                dec.wr_rd   = 1'b1;
                dec.op2_sel = Op2R2;
                unique case (funct)
                    FnAdd: dec.alu_op = AluAdd;
                    FnSub: dec.alu_op = AluSub;
                    FnMul: dec.alu_op = AluMul;
                    FnAnd: dec.alu_op = AluAnd;
                    FnOr:  dec.alu_op = AluOr;
                    FnNor: dec.alu_op = AluNor;
                    FnSlt: dec.alu_op = AluSlt;
                    FnSll: begin dec.alu_op = AluSll; dec.op2_sel = Op2Shamt; end
                    FnSrl: begin dec.alu_op = AluSrl; dec.op2_sel = Op2Shamt; end
                    FnJr: begin
                        dec.wr_rd   = 1'b0;
                        dec.op2_sel = Op2ImmSx;
                        dec.is_jr   = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OpAddi: begin dec.alu_op = AluAdd; dec.wr_rt = 1'b1; end
            OpMuli: begin dec.alu_op = AluMul; dec.wr_rt = 1'b1; end
            OpSlti: begin dec.alu_op = AluSlt; dec.wr_rt = 1'b1; end
            OpAndi: begin dec.alu_op = AluAnd; dec.op2_sel = Op2ImmZx; dec.wr_rt = 1'b1; end
            OpOri:  begin dec.alu_op = AluOr;  dec.op2_sel = Op2ImmZx; dec.wr_rt = 1'b1; end
            OpLui:  begin dec.wr_rt = 1'b1; dec.wd_lui = 1'b1; end
            OpLw: begin
                dec.alu_op = AluAdd;
                dec.is_lw  = 1'b1;
                dec.wr_rt  = 1'b1;
                dec.wd_mem = 1'b1;
            end
            OpSw:   begin dec.alu_op = AluAdd; dec.is_sw = 1'b1; end
            OpBeq:  begin dec.alu_op = AluSub; dec.op2_sel = Op2R2; dec.is_beq = 1'b1; end
            OpBne:  begin dec.alu_op = AluSub; dec.op2_sel = Op2R2; dec.is_bne = 1'b1; end
            OpJmp:  dec.is_jump = 1'b1;
            OpJal:  begin dec.is_jump = 1'b1; dec.is_jal = 1'b1; end
            OpPush: begin
                // SP-1 is computed from EXE on and loaded into SP in WB
                dec.alu_op  = AluSub;
                dec.op1_sp  = 1'b1;
                dec.op2_sel = Op2Const;
                dec.is_push = 1'b1;
            end
            OpPop: begin
                // SP+1 is loaded in EXE, so MEM reads at the updated SP
                dec.alu_op  = AluAdd;
                dec.op1_sp  = 1'b1;
                dec.op2_sel = Op2Const;
                dec.is_pop  = 1'b1;
                dec.wr_rt   = 1'b1;
                dec.wd_mem  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec = '0;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign trap = ~legal;
`else
    assign trap = 1'b0;
`endif

    control_unit_proc_sm u_proc_sm (
        .clk_i        (CLK),
        .rst_ni       (RST),
        .trap_i       (trap),
        .state_o      (state_q),
        .state_next_o (state_next)
    );

    // Control word for the state being entered. ALU/operand fields stay up from
    // EXE through WB so the ALU result feeds the MEM address and WB data.
    // reg_r is pulsed in DECODE only; the register file holds its read data.
    always_comb begin
        ctrl_d  = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
        unique case (state_next)
            StFetch: begin
                read_d            = 1'b1;
                ctrl_d[CtlMaSel2] = 1'b1;
            end
            StDecode: begin
                read_d            = 1'b1;
                ctrl_d[CtlMaSel2] = 1'b1;
                ctrl_d[CtlIrLoad] = 1'b1;
                ctrl_d[CtlRegR]   = 1'b1;
            end
            StExe, StMem, StWb: begin
                ctrl_d[CtlOp1Sel1]              = dec.op1_sp;
                ctrl_d[CtlOp2Sel4:CtlOp2Sel1]   = dec.op2_sel;
                ctrl_d[CtlAluMsb:CtlAluLsb]     = dec.alu_op;
                if (state_next == StExe) begin
                    ctrl_d[CtlSpLoad] = dec.is_pop;
                end
                if (state_next == StMem) begin
                    read_d            = dec.is_lw | dec.is_pop;
                    write_d           = dec.is_sw | dec.is_push;
                    ctrl_d[CtlMaSel1] = dec.is_push | dec.is_pop;
                    ctrl_d[CtlMdSel1] = dec.is_push;
                end
                if (state_next == StWb) begin
                    ctrl_d[CtlPcLoad] = 1'b1;
                    ctrl_d[CtlPcSel1] = dec.is_jr;
                    ctrl_d[CtlPcSel2] = (dec.is_beq & zero_q) | (dec.is_bne & ~zero_q);
                    ctrl_d[CtlPcSel3] = dec.is_jump;
                    ctrl_d[CtlSpLoad] = dec.is_push;
                    ctrl_d[CtlRegW]   = dec.wr_rd | dec.wr_rt | dec.is_jal;
                    ctrl_d[CtlWaSel1] = dec.wr_rt;
                    ctrl_d[CtlWaSel3] = dec.is_jal;
                    ctrl_d[CtlWdSel1] = dec.wd_mem;
                    ctrl_d[CtlWdSel2] = dec.wd_lui;
                    ctrl_d[CtlWdSel3] = dec.is_jal;
                end
            end
            default: ;  // reset-pending and HALT drive an all-zero word
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            read_q  <= read_d;
            write_q <= write_d;
            if (state_q == StExe) begin
                zero_q <= ZERO;
            end
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic err_q;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_next == StHalt);
        end
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign CTRL  = ctrl_q;
    assign READ  = read_q;
    assign WRITE = write_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit.
// Each instruction is held on INSTRUCTION for its five states and the
// registered outputs {ERR, READ, WRITE, CTRL} are compared once per state
// on the falling edge against hand-computed words.
module tb_control_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] INSTRUCTION = 32'h0;
    logic        ZERO = 1'b0;
    logic [31:0] CTRL;
    logic        READ, WRITE, ERR;

    int checks = 0;
    int errors = 0;

    // Hand-encoded instructions
    localparam logic [31:0] IAdd  = 32'h0022_1820;  // add r3,r1,r2
    localparam logic [31:0] IBeq  = 32'h1022_0005;  // beq r1,r2,5
    localparam logic [31:0] IBne  = 32'h1422_0005;  // bne r1,r2,5
    localparam logic [31:0] ISw   = 32'hAC22_0004;  // sw r2,4(r1)
    localparam logic [31:0] ILw   = 32'h8C22_0004;  // lw r2,4(r1)
    localparam logic [31:0] IPush = 32'h6CA0_0000;  // push r5
    localparam logic [31:0] IPop  = 32'h7006_0000;  // pop r6
    localparam logic [31:0] IJal  = 32'h0C00_0010;  // jal 0x10
    localparam logic [31:0] IAndi = 32'h3022_00FF;  // andi r2,r1,0xff
    localparam logic [31:0] IBad  = 32'hFC00_0000;  // opcode 0x3f

    localparam logic [31:0] WFetch  = 32'h0020_0000;
    localparam logic [31:0] WDecode = 32'h0020_0050;

    control_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTRUCTION (INSTRUCTION),
        .ZERO        (ZERO),
        .CTRL        (CTRL),
        .READ        (READ),
        .WRITE       (WRITE),
        .ERR         (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic err, input logic rd, input logic wr,
                                       input logic [31:0] c);
        return {29'd0, err, rd, wr, c};
    endfunction

    function automatic logic [63:0] outs();
        return {29'd0, ERR, READ, WRITE, CTRL};
    endfunction

    // Called on a falling edge; the next rising edge enters FETCH.
    task automatic run_instr(input string name, input logic [31:0] instr, input logic zero,
                             input logic [31:0] exe_w, input logic [31:0] mem_w,
                             input logic [31:0] wb_w, input logic mem_rd, input logic mem_wr);
        INSTRUCTION = instr;
        ZERO        = zero;
        @(negedge CLK); check({name, "_fetch"},  outs(), pk(1'b0, 1'b1, 1'b0, WFetch));
        @(negedge CLK); check({name, "_decode"}, outs(), pk(1'b0, 1'b1, 1'b0, WDecode));
        @(negedge CLK); check({name, "_exe"},    outs(), pk(1'b0, 1'b0, 1'b0, exe_w));
        @(negedge CLK); check({name, "_mem"},    outs(), pk(1'b0, mem_rd, mem_wr, mem_w));
        @(negedge CLK); check({name, "_wb"},     outs(), pk(1'b0, 1'b0, 1'b0, wb_w));
    endtask

    initial begin
        #1;
        check("reset", outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge CLK);
        check("reset_held", outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        RST = 1'b1;

        run_instr("add",      IAdd,  1'b0, 32'h0000_6000, 32'h0000_6000, 32'h0000_6081, 1'b0, 1'b0);
        run_instr("beq_t",    IBeq,  1'b1, 32'h0000_A000, 32'h0000_A000, 32'h0000_A005, 1'b0, 1'b0);
        run_instr("beq_nt",   IBeq,  1'b0, 32'h0000_A000, 32'h0000_A000, 32'h0000_A001, 1'b0, 1'b0);
        run_instr("bne_t",    IBne,  1'b0, 32'h0000_A000, 32'h0000_A000, 32'h0000_A005, 1'b0, 1'b0);
        run_instr("sw",       ISw,   1'b0, 32'h0000_4000, 32'h0000_4000, 32'h0000_4001, 1'b0, 1'b1);
        run_instr("lw",       ILw,   1'b0, 32'h0000_4000, 32'h0000_4000, 32'h0480_4081, 1'b1, 1'b0);
        run_instr("push",     IPush, 1'b0, 32'h0000_8600, 32'h0050_8600, 32'h0000_8701, 1'b0, 1'b1);
        run_instr("pop",      IPop,  1'b0, 32'h0000_4700, 32'h0010_4600, 32'h0480_4681, 1'b1, 1'b0);
        run_instr("jal",      IJal,  1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1200_0089, 1'b0, 1'b0);
        run_instr("andi",     IAndi, 1'b0, 32'h0001_9000, 32'h0001_9000, 32'h0401_9081, 1'b0, 1'b0);

        // Reset pulled during MEM of a store
        INSTRUCTION = ISw;
        @(negedge CLK); check("rst_sw_fetch",  outs(), pk(1'b0, 1'b1, 1'b0, WFetch));
        @(negedge CLK); check("rst_sw_decode", outs(), pk(1'b0, 1'b1, 1'b0, WDecode));
        @(negedge CLK); check("rst_sw_exe",    outs(), pk(1'b0, 1'b0, 1'b0, 32'h0000_4000));
        @(negedge CLK); check("rst_sw_mem",    outs(), pk(1'b0, 1'b0, 1'b1, 32'h0000_4000));
        #1 RST = 1'b0;
        #1 check("rst_async", outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge CLK); check("rst_low_edge", outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        RST = 1'b1;
        run_instr("sw_restart", ISw, 1'b0, 32'h0000_4000, 32'h0000_4000, 32'h0000_4001, 1'b0, 1'b1);

`ifdef CTRL_ILLEGAL_TRAP_EN
        INSTRUCTION = IBad;
        @(negedge CLK); check("bad_fetch",  outs(), pk(1'b0, 1'b1, 1'b0, WFetch));
        @(negedge CLK); check("bad_decode", outs(), pk(1'b0, 1'b1, 1'b0, WDecode));
        @(negedge CLK); check("bad_exe",    outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        INSTRUCTION = IAdd;  // HALT must not resume on a legal instruction
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); check("halt", outs(), pk(1'b1, 1'b0, 1'b0, 32'h0));
        end
        #1 RST = 1'b0;
        #1 check("halt_rst", outs(), pk(1'b0, 1'b0, 1'b0, 32'h0));
        @(negedge CLK);
        RST = 1'b1;
        run_instr("add_after_halt", IAdd, 1'b0, 32'h0000_6000, 32'h0000_6000, 32'h0000_6081,
                  1'b0, 1'b0);
`else
        run_instr("bad_nop", IBad, 1'b0, 32'h0, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
        run_instr("add_after_nop", IAdd, 1'b0, 32'h0000_6000, 32'h0000_6000, 32'h0000_6081,
                  1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
